seg_scan_capture: RTL and testbench
===================================

// Module: seg_scan_capture
// PURPOSE
//  Receive end of the 8-digit multiplexed seven-segment bus (seg/an): samples the scanned
//  lines, rebuilds the 8 digit codes, decodes 0-9 back to 4-bit values, flags whole frames.
//  Sits beside the display driver as an on-chip monitor / self-check for game screens.
// PARAMETERS
//  STABLE_CYCLES   16      cycles an+seg must be unchanged before a digit is latched (>=2)
//  TIMEOUT_CYCLES  200000  cycles without any latch before stale is raised
// PORTS
//  CLK100MHZ   in   1    system clock; all logic on rising edge
//  reset       in   1    synchronous, active-high reset
//  seg         in   8    seg[0:6]=a..g, seg[7]=dp; active-low (0 = lit)
//  an          in   8    an[i]=0 selects digit i; one-hot-low expected
//  dig_code    out  56   latched raw code of digit i at [7*i+6:7*i], seg[0] in MSB
//  dig_val     out  32   decoded value of digit i at [4*i+3:4*i]
//  dig_known   out  8    bit i = digit i decoded to 0-9
//  dig_dp      out  8    bit i = dp lit on digit i (optional feature)
//  frame_done  out  1    1-cycle pulse: all 8 digits latched since last pulse
//  an_err      out  1    1-cycle pulse: >1 anode low detected
//  stale       out  1    no latch for TIMEOUT_CYCLES
// BEHAVIOUR
//  Reset: dig_code=all 1s (blank), dig_val=0, dig_known=0, dig_dp=0, frame_done=0,
//   an_err=0, stale=0, FSM=IDLE, stable count=0, seen mask=0, timeout count=0.
//  Inputs registered once (1 cycle); all decisions use registered an_q/seg_q.
//  FSM:
//   IDLE:    an_q all 1s -> stay. Exactly one low -> SETTLE, count=1. >1 low -> an_err.
//   SETTLE:  an_q/seg_q equal previous cycle -> count+1; else count=1 (change restarts).
//            count==STABLE_CYCLES -> latch digit i, set seen[i], -> LATCHED.
//            an_q all 1s -> IDLE (no latch). >1 low -> an_err pulse, -> IDLE.
//   LATCHED: hold until an_q or seg_q changes -> re-evaluate as from IDLE that cycle.
//  Latch writes dig_code[i], dig_val[i], dig_known[i] on the same edge; other digits hold.
//  Decode (abcdefg): 0000001=0 1001111=1 0010010=2 0000110=3 1001100=4 0100100=5
//   0100000=6 0001111=7 0000000=8 0000100=9; any other code -> val 0, known 0.
//  Latch completing seen=8'hFF: frame_done=1 next cycle, seen cleared to 0 (latching digit
//   not pre-counted); a digit latched twice before completion counts once.
//  an_err: pulses once per entry into a multi-low condition, not every cycle it persists.
//  Timeout counter clears on every latch, saturates at TIMEOUT_CYCLES; stale=1 when
//   saturated, cleared on next latch edge.
//  Simultaneous latch + timeout saturation: latch wins, stale stays 0.
//  Reset mid-SETTLE or mid-frame: discards partial count and seen mask; outputs as reset.
//  Counter widths: $clog2(param+1); no wrap (saturating).
// CONFIGURATION
//  SEG_CAPTURE_DP_EN defined: seg[7] latched with its digit; dig_dp[i]=~seg_q[7].
//   dp change counts as a change for stability.
//  Not defined: seg[7] ignored entirely (no effect on stability); dig_dp tied 8'h00.
// TESTING
//  Reset then idle an=8'hFF 1000 cycles -> all outputs at reset values, no pulses.
//  Scan digits 0..7 with codes for 0,1,2,3,4,5,6,7, 32 cycles each -> dig_val=32'h76543210,
//   dig_known=8'hFF, one frame_done pulse after digit 7 latch.
//  Digit 3 held 10 cycles (< STABLE_CYCLES=16) -> digit 3 not latched, no frame_done.
//  an=8'b00111111 for 5 cycles -> exactly one an_err pulse, FSM back to IDLE, no latch.
//  Code 0110000 ("E") on digit 2 -> dig_code[2] updated, dig_known[2]=0, dig_val[2]=0.
//  TIMEOUT_CYCLES=100, stop scanning -> stale=1 at 100 cycles; next latch clears it.

Source files
------------

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: receive side of the 8-digit multiplexed seven-segment bus.
// Rebuilds digit codes, decodes 0-9, flags frames. Optional: SEG_CAPTURE_DP_EN.
module seg_scan_capture #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic [7:0]  seg,
    input  logic [7:0]  an,
    output logic [55:0] dig_code,
    output logic [31:0] dig_val,
    output logic [7:0]  dig_known,
    output logic [7:0]  dig_dp,
    output logic        frame_done,
    output logic        an_err,
    output logic        stale
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STABLE_MAX  = SW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);
    localparam logic [SW-1:0] CNT_ONE     = SW'(1);

`ifdef SEG_CAPTURE_DP_EN
    localparam logic [7:0] SEG_MASK = 8'hFF;
`else
    localparam logic [7:0] SEG_MASK = 8'h7F;
`endif

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        LATCHED
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [SW-1:0] cnt;
    logic [SW-1:0] cnt_n;
    logic [TW-1:0] tcnt;

    logic [7:0] an_q;
    logic [7:0] seg_q;
    logic [7:0] an_p;
    logic [7:0] seg_p;
    logic       multi_q;
    logic [7:0] seen;

    logic [7:0] low;
    logic       any_low;
    logic       one_low;
    logic       multi;
    logic       changed;
    logic       latch;
    logic [2:0] idx;
    logic [5:0] code_base;
    logic [4:0] val_base;
    logic [6:0] code7;
    logic [3:0] dec_val;
    logic       dec_known;
    logic [7:0] seen_n;

    // Input capture plus one cycle of history for the stability compare
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            an_q    <= 8'hFF;
            seg_q   <= 8'hFF & SEG_MASK;
            an_p    <= 8'hFF;
            seg_p   <= 8'hFF & SEG_MASK;
            multi_q <= 1'b0;
        end else begin
            an_q    <= an;
            seg_q   <= seg & SEG_MASK;
            an_p    <= an_q;
            seg_p   <= seg_q;
            multi_q <= multi;
        end
    end

    // Anode classification: none, exactly one, or several digits selected
    always_comb begin
        low     = ~an_q;
        any_low = |low;
        one_low = any_low && ((low & (low - 8'd1)) == 8'd0);
        multi   = any_low && !one_low;
        changed = (an_q != an_p) || (seg_q != seg_p);
    end

    // Selected digit index and its slice offsets in the packed outputs
    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (low[i]) idx = 3'(i);
        end
        code_base = {3'b000, idx} * 6'd7;
        val_base  = {idx, 2'b00};
    end

    // Segment code with a in the MSB, decoded back to a digit value
    always_comb begin
        code7 = {seg_q[0], seg_q[1], seg_q[2], seg_q[3],
                 seg_q[4], seg_q[5], seg_q[6]};
        dec_val   = 4'd0;
        dec_known = 1'b1;
        case (code7)
            7'b0000001: dec_val = 4'd0;
            7'b1001111: dec_val = 4'd1;
            7'b0010010: dec_val = 4'd2;
            7'b0000110: dec_val = 4'd3;
            7'b1001100: dec_val = 4'd4;
            7'b0100100: dec_val = 4'd5;
            7'b0100000: dec_val = 4'd6;
            7'b0001111: dec_val = 4'd7;
            7'b0000000: dec_val = 4'd8;
            7'b0000100: dec_val = 4'd9;
            default: begin
                dec_val   = 4'd0;
                dec_known = 1'b0;
            end
        endcase
    end

    // Capture FSM state register
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next state: settle on a single selected digit, latch once stable
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        latch   = 1'b0;
        unique case (state)
            IDLE: begin
                if (one_low) begin
                    state_n = SETTLE;
                    cnt_n   = CNT_ONE;
                end else begin
                    cnt_n = '0;
                end
            end
            SETTLE: begin
                if (!one_low) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    if (changed) begin
                        cnt_n = CNT_ONE;
                    end else if (cnt != STABLE_MAX) begin
                        cnt_n = cnt + CNT_ONE;
                    end
                    if (cnt_n == STABLE_MAX) begin
                        latch   = 1'b1;
                        state_n = LATCHED;
                    end
                end
            end
            LATCHED: begin
                if (changed) begin
                    if (one_low) begin
                        state_n = SETTLE;
                        cnt_n   = CNT_ONE;
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Digit storage: only the selected digit is written on a latch
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            dig_code  <= '1;
            dig_val   <= '0;
            dig_known <= '0;
        end else if (latch) begin
            dig_code[code_base +: 7] <= code7;
            dig_val[val_base +: 4]   <= dec_val;
            dig_known[idx]           <= dec_known;
        end
    end

`ifdef SEG_CAPTURE_DP_EN
    // Decimal point captured alongside its digit (active-low on the bus)
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            dig_dp <= '0;
        end else if (latch) begin
            dig_dp[idx] <= ~seg_q[7];
        end
    end
`else
    assign dig_dp = 8'h00;
`endif

    assign seen_n = seen | low;

    // Frame tracking: pulse once every digit has been latched at least once
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            seen       <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (latch) begin
                if (seen_n == 8'hFF) begin
                    seen       <= '0;
                    frame_done <= 1'b1;
                end else begin
                    seen <= seen_n;
                end
            end
        end
    end

    // Anode error pulses on entry into a multi-select condition only
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            an_err <= 1'b0;
        end else begin
            an_err <= multi && !multi_q;
        end
    end

    // Staleness: saturating count of cycles since the last latch
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            tcnt <= '0;
        end else if (latch) begin
            tcnt <= '0;
        end else if (tcnt != TIMEOUT_MAX) begin
            tcnt <= tcnt + TW'(1);
        end
    end

    assign stale = (tcnt == TIMEOUT_MAX);

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: directed scoreboard bench for seg_scan_capture.
// Built with SEG_CAPTURE_DP_EN undefined; TIMEOUT_CYCLES shortened to 100.
module tb_seg_scan_capture;

    logic        CLK100MHZ = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  seg = 8'hFF;
    logic [7:0]  an = 8'hFF;
    logic [55:0] dig_code;
    logic [31:0] dig_val;
    logic [7:0]  dig_known;
    logic [7:0]  dig_dp;
    logic        frame_done;
    logic        an_err;
    logic        stale;

    int total = 0;
    int bad = 0;
    int fd_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        int         idx;
        logic [6:0] code;
        logic [3:0] val;
        logic       known;
    } exp_t;

    exp_t sb[$];

    logic [6:0] codes [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    seg_scan_capture #(
        .STABLE_CYCLES (16),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .CLK100MHZ (CLK100MHZ),
        .reset     (reset),
        .seg       (seg),
        .an        (an),
        .dig_code  (dig_code),
        .dig_val   (dig_val),
        .dig_known (dig_known),
        .dig_dp    (dig_dp),
        .frame_done(frame_done),
        .an_err    (an_err),
        .stale     (stale)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    // Pulse counters for frame_done and an_err
    always @(posedge CLK100MHZ) begin
        if (frame_done) fd_cnt <= fd_cnt + 1;
        if (an_err) err_cnt <= err_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK100MHZ);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mk_seg(input logic [6:0] c,
                                          input logic dp_lit);
        return {~dp_lit, c[0], c[1], c[2], c[3], c[4], c[5], c[6]};
    endfunction

    task automatic sel_digit(input int i, input logic [6:0] c);
        an  = ~(8'd1 << i);
        seg = mk_seg(c, 1'b0);
    endtask

    task automatic push_exp(input int i, input logic [6:0] c,
                            input logic [3:0] v, input logic k);
        exp_t e;
        e.idx = i;
        e.code = c;
        e.val = v;
        e.known = k;
        sb.push_back(e);
    endtask

    task automatic check_pop(input string tag);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL %s: observed=empty expected=entry", tag);
        end else begin
            total--;
            e = sb.pop_front();
            chk({tag, "_code"}, 64'(dig_code[e.idx*7 +: 7]), 64'(e.code));
            chk({tag, "_val"}, 64'(dig_val[e.idx*4 +: 4]), 64'(e.val));
            chk({tag, "_known"}, 64'(dig_known[e.idx]), 64'(e.known));
        end
    endtask

    initial begin
        // Reset and the reset-state outputs
        reset = 1'b1;
        an = 8'hFF;
        seg = 8'hFF;
        tick(3);
        reset = 1'b0;
        chk("rst_code", 64'(dig_code), {8'h00, 56'hFF_FFFF_FFFF_FFFF});
        chk("rst_val", 64'(dig_val), 64'h0);
        chk("rst_known", 64'(dig_known), 64'h0);
        chk("rst_dp", 64'(dig_dp), 64'h0);
        chk("rst_fd", 64'(frame_done), 64'h0);
        chk("rst_err", 64'(an_err), 64'h0);
        chk("rst_stale", 64'(stale), 64'h0);

        // Idle bus: stale appears exactly at the timeout, nothing else moves
        tick(99);
        chk("stale_99", 64'(stale), 64'h0);
        tick(1);
        chk("stale_100", 64'(stale), 64'h1);
        tick(900);
        chk("idle_code", 64'(dig_code), {8'h00, 56'hFF_FFFF_FFFF_FFFF});
        chk("idle_known", 64'(dig_known), 64'h0);
        chk("idle_fd", 64'(fd_cnt), 64'd0);
        chk("idle_err", 64'(err_cnt), 64'd0);

        // Full frame scan 0..7 showing values 0..7
        for (int i = 0; i < 8; i++) begin
            push_exp(i, codes[i], 4'(i), 1'b1);
            sel_digit(i, codes[i]);
            tick(32);
            check_pop($sformatf("scan%0d", i));
            if (i == 0) chk("stale_clr", 64'(stale), 64'h0);
            if (i == 6) chk("fd_before", 64'(fd_cnt), 64'd0);
        end
        an = 8'hFF;
        tick(5);
        chk("frame_val", 64'(dig_val), 64'h7654_3210);
        chk("frame_known", 64'(dig_known), 64'hFF);
        chk("frame_fd", 64'(fd_cnt), 64'd1);

        // Too-short hold on digit 3 must not latch
        sel_digit(3, codes[8]);
        tick(10);
        an = 8'hFF;
        tick(20);
        chk("short_val", 64'(dig_val[15:12]), 64'd3);
        chk("short_code", 64'(dig_code[27:21]), 64'(codes[3]));
        chk("short_fd", 64'(fd_cnt), 64'd1);
        chk("short_err", 64'(err_cnt), 64'd0);

        // Two anodes low for several cycles: a single error pulse
        an = 8'b0011_1111;
        seg = mk_seg(codes[8], 1'b0);
        tick(5);
        an = 8'hFF;
        tick(5);
        chk("multi_err", 64'(err_cnt), 64'd1);
        chk("multi_val", 64'(dig_val), 64'h7654_3210);
        chk("multi_fd", 64'(fd_cnt), 64'd1);

        // Non-digit code on digit 2
        push_exp(2, 7'b0110000, 4'd0, 1'b0);
        sel_digit(2, 7'b0110000);
        tick(32);
        check_pop("glyph_e");
        chk("e_known", 64'(dig_known), 64'hFB);
        chk("e_val", 64'(dig_val), 64'h7654_3010);
        an = 8'hFF;
        tick(5);

        // Exact latch latency: 17 edges from drive to latch
        push_exp(5, codes[9], 4'd9, 1'b1);
        sel_digit(5, codes[9]);
        tick(16);
        chk("lat16_val", 64'(dig_val[23:20]), 64'd5);
        tick(1);
        check_pop("lat17");
        an = 8'hFF;

        // Timeout measured from the latch edge, then cleared by a latch
        tick(99);
        chk("to_99", 64'(stale), 64'h0);
        tick(1);
        chk("to_100", 64'(stale), 64'h1);
        push_exp(6, codes[0], 4'd0, 1'b1);
        sel_digit(6, codes[0]);
        for (int k = 0; k < 16; k++) begin
            tick(1);
            seg[7] = ~seg[7];
        end
        chk("to_hold", 64'(stale), 64'h1);
        tick(1);
        chk("to_clear", 64'(stale), 64'h0);
        check_pop("dp_ignored");
        chk("dp_tied", 64'(dig_dp), 64'h0);
        an = 8'hFF;
        tick(5);
        chk("end_fd", 64'(fd_cnt), 64'd1);
        chk("end_err", 64'(err_cnt), 64'd1);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
